// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C master controller.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    DATA     = 3'd4,
    DATA_ACK = 3'd5,
    STOP     = 3'd6
  } i2c_state_t;

endpackage

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master sequencer. SCL timing comes from an external tick
// divider: sample_h ends an SCL-high half, sample_l ends an SCL-low half.
//
// state    | meaning
// IDLE     | bus released, waiting for a command
// START    | SDA pulled low with SCL high, waiting for the first sample_h
// ADDR     | shifting {addr, rw} out MSB first
// ADDR_ACK | SDA released, slave ACK sampled at the end of the high half
// DATA     | write: shifting wdata out; read: shifting SDA into rdata
// DATA_ACK | write: sample slave ACK; read: master NACK (SDA released)
// STOP     | bit_cnt 0: wait SCL rise, 1: release SDA, 2: done and back to IDLE
module i2c_master_ctrl
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_rw,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              en_clk,
  input  logic              sample_h,
  input  logic              sample_l,
  output logic              scl_o,
  output logic              sda_o,
  input  logic              sda_i,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              ack_err
);

  i2c_state_t        state_q, state_d;
  logic              scl_q, scl_d;
  logic              sda_q, sda_d;
  logic              en_clk_q, en_clk_d;
  logic              done_q, done_d;
  logic              ack_err_q, ack_err_d;
  logic              rw_q, rw_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W:0]   addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0] wdata_sh_q, wdata_sh_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept;

  // The done cycle is still treated as busy so a held cmd_valid is taken
  // no earlier than the cycle after done.
  assign cmd_ready = (state_q == IDLE) && !done_q;
  assign accept    = cmd_valid && cmd_ready;
  assign en_clk    = en_clk_q;
  assign scl_o     = scl_q;
  assign sda_o     = sda_q;
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign ack_err   = ack_err_q;

  // State and output registers, all forced to the idle bus on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      en_clk_q   <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      rw_q       <= 1'b0;
      bit_cnt_q  <= 3'd0;
      addr_sh_q  <= '0;
      wdata_sh_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      en_clk_q   <= en_clk_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      rw_q       <= rw_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_sh_q  <= addr_sh_d;
      wdata_sh_q <= wdata_sh_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state logic; sample_h is checked first so it wins over sample_l.
  always_comb begin
    state_d    = state_q;
    scl_d      = scl_q;
    sda_d      = sda_q;
    en_clk_d   = en_clk_q;
    done_d     = 1'b0;
    ack_err_d  = ack_err_q;
    rw_d       = rw_q;
    bit_cnt_d  = bit_cnt_q;
    addr_sh_d  = addr_sh_q;
    wdata_sh_d = wdata_sh_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_sh_d  = {cmd_addr, cmd_rw};
          wdata_sh_d = cmd_wdata;
          rw_d       = cmd_rw;
          ack_err_d  = 1'b0;
          en_clk_d   = 1'b1;
          sda_d      = 1'b0;
          bit_cnt_d  = 3'd0;
          state_d    = START;
        end
      end
      START: begin
        if (sample_h) begin
          scl_d     = 1'b0;
          sda_d     = addr_sh_q[ADDR_W];
          addr_sh_d = {addr_sh_q[ADDR_W-1:0], 1'b0};
          bit_cnt_d = 3'd0;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (sample_h) begin
          scl_d = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            sda_d   = 1'b1;
            state_d = ADDR_ACK;
          end else begin
            sda_d     = addr_sh_q[ADDR_W];
            addr_sh_d = {addr_sh_q[ADDR_W-1:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (sample_l) begin
          scl_d = 1'b1;
        end
      end
      ADDR_ACK: begin
        if (sample_h) begin
          scl_d     = 1'b0;
          bit_cnt_d = 3'd0;
          if (!sda_i) begin
            sda_d      = rw_q ? 1'b1 : wdata_sh_q[DATA_W-1];
            wdata_sh_d = {wdata_sh_q[DATA_W-2:0], 1'b0};
            state_d    = DATA;
          end else begin
            // NACK: this falling edge doubles as the first step of STOP.
            ack_err_d = 1'b1;
            sda_d     = 1'b0;
            state_d   = STOP;
          end
        end else if (sample_l) begin
          scl_d = 1'b1;
        end
      end
      DATA: begin
        if (sample_h) begin
          scl_d = 1'b0;
          if (rw_q) begin
            rdata_d = {rdata_q[DATA_W-2:0], sda_i};
          end
          if (bit_cnt_q == 3'd7) begin
            sda_d   = 1'b1;
            state_d = DATA_ACK;
          end else begin
            sda_d      = rw_q ? 1'b1 : wdata_sh_q[DATA_W-1];
            wdata_sh_d = {wdata_sh_q[DATA_W-2:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end
        end else if (sample_l) begin
          scl_d = 1'b1;
        end
      end
      DATA_ACK: begin
        if (sample_h) begin
          scl_d     = 1'b0;
          sda_d     = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = STOP;
          if (!rw_q && sda_i) begin
            ack_err_d = 1'b1;
          end
        end else if (sample_l) begin
          scl_d = 1'b1;
        end
      end
      STOP: begin
        case (bit_cnt_q)
          3'd0: begin
            if (!sample_h && sample_l) begin
              scl_d     = 1'b1;
              bit_cnt_d = 3'd1;
            end
          end
          3'd1: begin
            if (sample_h) begin
              sda_d     = 1'b1;
              bit_cnt_d = 3'd2;
            end
          end
          default: begin
            done_d    = 1'b1;
            en_clk_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = IDLE;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
